// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   F3_*       RV32I load/store funct3 size/sign codes
//   state_e    responder FSM states
//   f3_illegal returns 1 when a funct3 code has no meaning for the given access direction

package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Stores only have signed encodings (SB/SH/SW); loads also allow the unsigned forms.
    function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
        logic ill;
        if (write) begin
            ill = (funct3 > F3_W);
        end else begin
            ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        return ill;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for RV32I loads and stores (purely combinational).
//
// Ports:
//   funct3      in   access size/sign code
//   addr_lo     in   byte offset within the word (addr[1:0])
//   word        in   full storage word currently addressed (load source)
//   wdata       in   right-aligned store data (rs2)
//   byte_en     out  per-lane write enables for a store of this size/offset
//   wdata_lane  out  store data replicated so every enabled lane sees its byte
//   rdata_ext   out  selected byte/half/word, sign- or zero-extended to 32 bits
//   misalign    out  halfword on odd address or word not on a 4-byte boundary

module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    // Bring the addressed lane down to bit 0 so byte/half selection is a fixed slice.
    logic [31:0] shifted;
    assign shifted = word >> {addr_lo, 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'd0;
        rdata_ext  = 32'd0;
        misalign   = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                rdata_ext = {24'd0, shifted[7:0]};
            end
            F3_H: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                misalign  = addr_lo[0];
                rdata_ext = {16'd0, shifted[15:0]};
            end
            F3_W: begin
                misalign   = |addr_lo;
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one RV32I load/store at a time, waits LATENCY cycles,
// then presents a response held until the core takes it.
//
// Parameters:
//   DEPTH_WORDS  32-bit words of storage (power of two, 4..65536)
//   LATENCY      wait cycles between accept and response (0..15)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  high only while idle
//   req_write   in   1 = store, 0 = load
//   req_funct3  in   access size/sign code
//   req_addr    in   byte address
//   req_wdata   in   right-aligned store data
//   rsp_valid   out  response present
//   rsp_ready   in   core takes the response
//   rsp_rdata   out  extended load data; 0 for stores and errors
//   rsp_error   out  misaligned, out of range or illegal funct3

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;

    // With LATENCY=0 the response is formed on the accept edge itself, before the
    // latched copy exists, so in IDLE the live request fields are the operands.
    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic        in_idle;
    assign in_idle    = (state_q == IDLE);
    assign cur_write  = in_idle ? req_write  : write_q;
    assign cur_funct3 = in_idle ? req_funct3 : funct3_q;
    assign cur_addr   = in_idle ? req_addr   : addr_q;
    assign cur_wdata  = in_idle ? req_wdata  : wdata_q;

    assign accept = req_valid && in_idle;

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic          out_of_range;
    logic          bad_funct3;
    logic          misalign;
    logic          err;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;

    assign word_idx     = cur_addr[AW+1:2];
    assign rd_word      = mem[word_idx];
    // Any set bit above the index field means addr[31:2] >= DEPTH_WORDS.
    assign out_of_range = |cur_addr[31:AW+2];
    assign bad_funct3   = f3_illegal(cur_write, cur_funct3);
    assign err          = misalign || out_of_range || bad_funct3;

    dmem_lane_align u_lane_align (
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .word       (rd_word),
        .wdata      (cur_wdata),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Always return to IDLE, so a new request waits at least one cycle.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                rsp_error_q <= err;
                rsp_rdata_q <= (err || cur_write) ? 32'd0 : rdata_ext;
            end
        end
    end

    // Storage is never cleared; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 0) checked against a
// byte-addressed reference memory kept in the bench.

module tb_dmem_responder;

    localparam int unsigned DEP0 = 16;
    localparam int unsigned DEP1 = 32;
    localparam int unsigned DEP2 = 16;

    logic        clk;
    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_error  [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage, one byte per address.
    logic [7:0] mem_b [3][128];

    dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    dmem_responder #(.DEPTH_WORDS(DEP2), .LATENCY(0)) u_dut2 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int depth_of(input int d);
        return (d == 1) ? int'(DEP1) : ((d == 0) ? int'(DEP0) : int'(DEP2));
    endfunction

    function automatic int cycles_of(input int d);
        // Cycles from accept to first visible rsp_valid: LATENCY + 1.
        return (d == 1) ? 4 : ((d == 0) ? 2 : 1);
    endfunction

    // Reference behaviour of one access, stated directly from the RV32I rules.
    function automatic void model(input int d, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int size;
        int base;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (wr && f3 > 3'd2) size = 0;
        rd = 32'd0;
        er = (size == 0);
        if (!er) er = ((a >> 2) >= 32'(depth_of(d))) || ((a % 32'(size)) != 32'd0);
        if (er) return;
        base = int'(a);
        if (wr) begin
            for (int i = 0; i < size; i++) mem_b[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[d][base + i];
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    // Drives one full transaction; scrambles the request fields after accept.
    task automatic do_txn(input int d, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit stable, output bit done_ok);
        int n;
        lat     = -1;
        stable  = 1'b1;
        done_ok = 1'b0;
        rd      = 'x;
        er      = 1'bx;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        rsp_ready[d]  = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_write[d]  = 1'($urandom);
            req_funct3[d] = 3'($urandom);
            req_addr[d]   = $urandom;
            req_wdata[d]  = $urandom;
            if (rsp_valid[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            req_valid[d] = 1'b0;
            return;
        end
        rd = rsp_rdata[d];
        er = rsp_error[d];
        if (req_ready[d] !== 1'b0) stable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd || rsp_error[d] !== er ||
                req_ready[d] !== 1'b0) stable = 1'b0;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        done_ok = (rsp_valid[d] === 1'b0) && (req_ready[d] === 1'b1);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; req_write[d] = 1'b0;
            req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (req_ready[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_req_ready[%0d]: got %b required 1", d, req_ready[d]);
            end
            n_tests++;
            if (rsp_valid[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b required 0", d, rsp_valid[d]);
            end
            n_tests++;
            if (rsp_rdata[d] !== 32'd0 || rsp_error[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_data[%0d]: got %h/%b required 0/0", d, rsp_rdata[d],
                         rsp_error[d]);
            end
        end
        for (int d = 0; d < 3; d++) reset[d] = 1'b0;
    endtask

    task automatic test_fill(input int d);
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat;
        bit st, dn;
        for (int w = 0; w < depth_of(d); w++) begin
            wd = $urandom;
            model(d, 1'b1, 3'd2, 32'(w * 4), wd, erd, eer);
            do_txn(d, 1'b1, 3'd2, 32'(w * 4), wd, 0, rd, er, lat, st, dn);
            n_tests++;
            if (rd !== erd || er !== eer || lat != cycles_of(d) || !dn) begin
                n_fail++;
                $display("FAIL fill[%0d] w%0d: got rd=%h err=%b lat=%0d done=%b required %h/%b/%0d/1",
                         d, w, rd, er, lat, dn, erd, eer, cycles_of(d));
            end
        end
    endtask

    // Directed sequence on the LATENCY=1 instance with fixed expected values.
    task automatic test_directed();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        bit st, dn;
        logic [31:0] addrs [9];
        logic [2:0]  f3s   [9];
        bit          wrs   [9];
        logic [31:0] wds   [9];
        logic [31:0] exp_d [9];
        logic        exp_e [9];
        string       names [9];
        addrs = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10, 32'h12};
        f3s   = '{3'd2, 3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd2, 3'd2};
        wrs   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        wds   = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000000AA, 32'h0,
                  32'h12345678};
        exp_d = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                  32'h0000BEEF, 32'h0, 32'hDEADAAEF, 32'h0};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        names = '{"sw_10", "lw_10", "lb_13", "lbu_13", "lh_12", "lhu_10", "sb_11",
                  "lw_after_sb", "sw_misaligned"};
        for (int i = 0; i < 9; i++) begin
            model(0, wrs[i], f3s[i], addrs[i], wds[i], mrd, mer);
            do_txn(0, wrs[i], f3s[i], addrs[i], wds[i], 0, rd, er, lat, st, dn);
            n_tests++;
            if (rd !== exp_d[i] || er !== exp_e[i]) begin
                n_fail++;
                $display("FAIL %s: got rd=%h err=%b required rd=%h err=%b", names[i], rd, er,
                         exp_d[i], exp_e[i]);
            end
            n_tests++;
            if (lat != 2 || !dn) begin
                n_fail++;
                $display("FAIL %s_timing: got lat=%0d done=%b required lat=2 done=1", names[i],
                         lat, dn);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        bit st, dn;
        do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_after_bad_sw: got %h/%b required DEADAAEF/0", rd, er);
        end
        do_txn(0, 1'b0, 3'd2, 32'(DEP0 * 4), 32'h0, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++; $display("FAIL lw_out_of_range: got %h/%b required 0/1", rd, er);
        end
        do_txn(0, 1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++; $display("FAIL load_f3_3: got %h/%b required 0/1", rd, er);
        end
        do_txn(0, 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++; $display("FAIL store_f3_4: got %h/%b required 0/1", rd, er);
        end
        do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'hDEADAAEF) begin
            n_fail++; $display("FAIL lw_after_bad_store: got %h required DEADAAEF", rd);
        end
        model(0, 1'b0, 3'd2, 32'h10, 32'h0, mrd, mer);
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat;
        bit st, dn;
        do_txn(0, 1'b0, 3'd1, 32'h12, 32'h0, 5, rd, er, lat, st, dn);
        n_tests++;
        if (!st || !dn || rd !== 32'hFFFFDEAD || er !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure: got stable=%b done=%b rd=%h err=%b required 1/1/FFFFDEAD/0",
                     st, dn, rd, er);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        bit st, dn, seen;
        model(1, 1'b1, 3'd2, 32'h20, 32'hA5A5A5A5, mrd, mer);
        do_txn(1, 1'b1, 3'd2, 32'h20, 32'hA5A5A5A5, 0, rd, er, lat, st, dn);
        n_tests++;
        if (lat != 4 || er !== 1'b0 || !dn) begin
            n_fail++;
            $display("FAIL lat3_sw: got lat=%0d err=%b done=%b required 4/0/1", lat, er, dn);
        end
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset[1] = 1'b0;
        n_tests++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 ||
            rsp_error[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got ready=%b valid=%b rd=%h err=%b required 1/0/0/0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_error[1]);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_response: got rsp_valid=1 required 0");
        end
        do_txn(1, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er, lat, st, dn);
        n_tests++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_write: got %h/%b required A5A5A5A5/0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic er, eer;
        logic [2:0] f3;
        bit wr, st, dn;
        int lat, hold;
        for (int i = 0; i < 150; i++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = 32'($urandom_range(0, DEP0 * 4 + 7));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            model(0, wr, f3, a, wd, erd, eer);
            do_txn(0, wr, f3, a, wd, hold, rd, er, lat, st, dn);
            n_tests++;
            if (rd !== erd || er !== eer) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%b f3=%0d a=%h: got %h/%b required %h/%b", i, wr,
                         f3, a, rd, er, erd, eer);
            end
            n_tests++;
            if (lat != 2 || !st || !dn) begin
                n_fail++;
                $display("FAIL random_hs[%0d]: got lat=%0d stable=%b done=%b required 2/1/1", i,
                         lat, st, dn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [$];
        logic        exp_er [$];
        logic [31:0] mrd, a, wd;
        logic mer, er_e;
        logic [31:0] rd_e;
        logic [2:0] f3;
        bit wr, pend;
        int accepts;
        logic [2:0] f3_tab [5];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        accepts = 0;
        pend = 1'b0;
        rsp_ready[2] = 1'b1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (pend) begin
                rd_e = exp_rd.pop_front();
                er_e = exp_er.pop_front();
                n_tests++;
                if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== rd_e || rsp_error[2] !== er_e) begin
                    n_fail++;
                    $display("FAIL b2b cyc%0d: got v=%b rd=%h err=%b required 1/%h/%b", cyc,
                             rsp_valid[2], rsp_rdata[2], rsp_error[2], rd_e, er_e);
                end
            end else if (rsp_valid[2] !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b_spurious cyc%0d: got rsp_valid=%b required 0", cyc,
                         rsp_valid[2]);
            end
            pend = 1'b0;
            if (cyc == 40) begin
                req_valid[2] = 1'b0;
            end else begin
                wr = 1'($urandom_range(0, 1));
                f3 = f3_tab[$urandom_range(0, 4)];
                a  = 32'($urandom_range(0, DEP2 * 4 - 1));
                wd = $urandom;
                req_valid[2] = 1'b1; req_write[2] = wr; req_funct3[2] = f3;
                req_addr[2] = a; req_wdata[2] = wd;
                if (req_ready[2] === 1'b1) begin
                    model(2, wr, f3, a, wd, mrd, mer);
                    exp_rd.push_back(mrd);
                    exp_er.push_back(mer);
                    pend = 1'b1;
                    accepts++;
                end
            end
        end
        rsp_ready[2] = 1'b0;
        n_tests++;
        if (accepts != 20) begin
            n_fail++; $display("FAIL b2b_rate: got %0d accepts in 40 cycles required 20", accepts);
        end
    endtask

    initial begin
        test_reset();
        test_fill(0);
        test_fill(2);
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
